// File: rtl/pcm_shared_mem.sv
// Shared-memory responder: four CPU request ports with round-robin
// arbitration plus a fixed-priority Nios Avalon-MM slave, all sharing one
// single-port RAM. While init is high, only Nios can access the RAM.
// Optional feature macro: PCM_MEM_OOR_TRAP_EN. When it is defined, CPU
// accesses with nonzero upper address bits are trapped and the oor_err port
// exists. When it is not defined, the upper address bits alias.
module pcm_shared_mem #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CPU_AW  = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        init,
  input  logic [N_PORTS-1:0]          cpu_req,
  input  logic [N_PORTS-1:0]          cpu_write,
  input  logic [N_PORTS*CPU_AW-1:0]   cpu_addr,
  input  logic [N_PORTS*DATA_W-1:0]   cpu_wdata,
  output logic [N_PORTS-1:0]          cpu_ready,
  output logic [N_PORTS*DATA_W-1:0]   cpu_rdata,
  input  logic [ADDR_W-1:0]           pcm_mem_mm_address,
  input  logic                        pcm_mem_mm_chipselect,
  input  logic                        pcm_mem_mm_clken,
  input  logic                        pcm_mem_mm_write,
  input  logic [DATA_W-1:0]           pcm_mem_mm_writedata,
  input  logic [1:0]                  pcm_mem_mm_byteenable,
  output logic [DATA_W-1:0]           pcm_mem_mm_readdata
`ifdef PCM_MEM_OOR_TRAP_EN
  ,
  output logic [N_PORTS-1:0]          oor_err
`endif
);

  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned HI_W  = CPU_AW - ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT  = 2'd1,
    S_RSP  = 2'd2
  } state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [N_PORTS-1:0] ready_q, ready_d;
  logic [DATA_W-1:0]  rdata_q [N_PORTS];
  logic [DATA_W-1:0]  readdata_q;
  logic               oor_c;
`ifdef PCM_MEM_OOR_TRAP_EN
  logic               oor_q, oor_d;
  logic [N_PORTS-1:0] oor_err_q, oor_err_d;
  logic [N_PORTS-1:0] hi_nz_a;
`else
  logic               unused_addr_c;
`endif

  logic [ADDR_W-1:0]  lo_addr_a [N_PORTS];
  logic [DATA_W-1:0]  wdata_a   [N_PORTS];

  logic               nios_acc_c, nios_wr_c, nios_rd_c;
  logic               cpu_wr_c, cpu_rd_c;
  logic [IDX_W-1:0]   sel_idx_c, p_c;
  logic               sel_vld_c;

  // Unpack the per-port buses and pack the registered read data.
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign lo_addr_a[p] = cpu_addr[p*CPU_AW +: ADDR_W];
    assign wdata_a[p]   = cpu_wdata[p*DATA_W +: DATA_W];
    assign cpu_rdata[p*DATA_W +: DATA_W] = rdata_q[p];
`ifdef PCM_MEM_OOR_TRAP_EN
    assign hi_nz_a[p] = |cpu_addr[p*CPU_AW + ADDR_W +: HI_W];
`endif
  end

`ifdef PCM_MEM_OOR_TRAP_EN
  assign oor_c   = oor_q;
  assign oor_err = oor_err_q;
`else
  assign oor_c         = 1'b0;
  assign unused_addr_c = ^cpu_addr;
`endif

  assign nios_acc_c = pcm_mem_mm_chipselect & pcm_mem_mm_clken;
  assign nios_wr_c  = nios_acc_c & pcm_mem_mm_write & ~reset;
  assign nios_rd_c  = nios_acc_c & ~pcm_mem_mm_write;

  assign cpu_ready           = ready_q;
  assign pcm_mem_mm_readdata = readdata_q;

  // Round-robin pick: first requesting port at or after rr_ptr.
  always_comb begin
    sel_vld_c = 1'b0;
    sel_idx_c = '0;
    p_c       = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      p_c = IDX_W'((32'(rr_ptr_q) + k) % N_PORTS);
      if (!sel_vld_c && cpu_req[p_c]) begin
        sel_vld_c = 1'b1;
        sel_idx_c = p_c;
      end
    end
  end

  // Next-state logic for the IDLE -> GNT -> RSP transaction FSM.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d      = g_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ready_d  = '0;
    cpu_wr_c = 1'b0;
    cpu_rd_c = 1'b0;
`ifdef PCM_MEM_OOR_TRAP_EN
    oor_d     = oor_q;
    oor_err_d = oor_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!init && sel_vld_c) begin
          g_d     = sel_idx_c;
          we_d    = cpu_write[sel_idx_c];
          addr_d  = lo_addr_a[sel_idx_c];
          wdata_d = wdata_a[sel_idx_c];
`ifdef PCM_MEM_OOR_TRAP_EN
          oor_d   = hi_nz_a[sel_idx_c];
`endif
          state_d = S_GNT;
        end
      end
      S_GNT: begin
        // Nios owns the RAM port this cycle; retry next cycle.
        if (!nios_acc_c) begin
          cpu_wr_c    = we_q & ~oor_c & ~reset;
          cpu_rd_c    = ~we_q;
          ready_d[g_q] = 1'b1;
`ifdef PCM_MEM_OOR_TRAP_EN
          if (oor_q) oor_err_d[g_q] = 1'b1;
`endif
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        rr_ptr_d = (g_q == IDX_W'(N_PORTS - 1)) ? '0 : g_q + IDX_W'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request fields, and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      g_q        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= '0;
      readdata_q <= '0;
      for (int unsigned p = 0; p < N_PORTS; p++) rdata_q[p] <= '0;
`ifdef PCM_MEM_OOR_TRAP_EN
      oor_q      <= 1'b0;
      oor_err_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q      <= g_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
`ifdef PCM_MEM_OOR_TRAP_EN
      oor_q     <= oor_d;
      oor_err_q <= oor_err_d;
`endif
      if (cpu_rd_c) rdata_q[g_q] <= oor_c ? '0 : mem_q[addr_q];
      if (nios_rd_c) readdata_q <= mem_q[pcm_mem_mm_address];
    end
  end

  // RAM write port: Nios byte-lane writes take priority over CPU writes.
  always_ff @(posedge clk) begin
    if (nios_wr_c) begin
      if (pcm_mem_mm_byteenable[0]) mem_q[pcm_mem_mm_address][7:0]  <= pcm_mem_mm_writedata[7:0];
      if (pcm_mem_mm_byteenable[1]) mem_q[pcm_mem_mm_address][15:8] <= pcm_mem_mm_writedata[15:8];
    end else if (cpu_wr_c) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

endmodule
